host_cmd_init: RTL and testbench
================================

// Module: host_cmd_init
// PURPOSE
//  Host-side initiator for the logic-analyzer command protocol: the other end of the command/config block.
//  Takes one request (op/addr/data), emits the 16-bit cmd to the command UART transmitter, then collects
//  and checks the 8-bit response(s) from the UART receiver. Dump responses are streamed into a capture buffer.
//  Used in the host bridge and as a synthesizable host model in system benches.
// PARAMETERS
//  ENTRIES      384      channel RAM depth; a dump returns exactly ENTRIES-1 bytes
//  LOG2         9        width of dump write address
//  TIMEOUT_CYC  1000000  max clk cycles between cmd_sent and each response byte before TIMEOUT
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous, active-high reset
//  req_vld      in   1      request strobe; accepted only when req_rdy=1
//  req_op       in   2      00 RD, 01 WR, 10 DMP, 11 reserved (sent as-is)
//  req_addr     in   6      register addr (RD/WR); for DMP, req_addr[2:0] = channel 1..5
//  req_data     in   8      write data (WR); sent as 8'h00 for other ops
//  req_rdy      out  1      1 in IDLE only
//  cmd          out  16     {op, addr, data}, registered at request accept, held until next accept
//  snd_cmd      out  1      one-cycle pulse to UART tx
//  cmd_sent     in   1      UART tx finished the 2-byte cmd (one-cycle pulse)
//  resp         in   8      received byte from UART rx
//  resp_rdy     in   1      level; resp valid until clr_resp_rdy
//  clr_resp_rdy out  1      one-cycle pulse consuming resp
//  dump_we      out  1      one-cycle pulse per dump byte
//  dump_waddr   out  LOG2   0..ENTRIES-2, increments after each dump_we
//  dump_wdata   out  8      dump byte (registered copy of resp)
//  rd_data      out  8      last RD response byte
//  done         out  1      one-cycle pulse at end of every request
//  status       out  2      valid with done, held: 00 OK, 01 NACK, 10 TIMEOUT, 11 BADRESP
// BEHAVIOUR
//  Reset: state IDLE; req_rdy=1 at reset; cmd, rd_data, dump_waddr, dump_wdata, status, timer = 0;
//   snd_cmd, clr_resp_rdy, dump_we, done = 0. Reset mid-request aborts it, no done pulse.
//  States: IDLE, SEND, WAIT_SENT, WAIT_RESP, DUMP_RX, FIN.
//  IDLE: req_vld -> latch cmd, clear dump_waddr/timer -> SEND. Stray resp_rdy in IDLE: clr_resp_rdy, discard.
//  SEND: snd_cmd=1 for one cycle -> WAIT_SENT. Latency req accept -> snd_cmd = 1 cycle.
//  WAIT_SENT: wait for cmd_sent (no timeout; tx always completes); resp_rdy may already be high and is held.
//   cmd_sent -> WAIT_RESP (op!=DMP) or DUMP_RX (op=DMP); timer cleared.
//  WAIT_RESP: timer++ each cycle; on resp_rdy: clr_resp_rdy, classify, -> FIN:
//   RD: rd_data<=resp, OK (any value legal). WR: A5 OK, EE NACK, else BADRESP.
//   op 11: EE NACK, else BADRESP. timer reaching TIMEOUT_CYC first -> TIMEOUT.
//  DUMP_RX: on resp_rdy: clr_resp_rdy, dump_we next cycle with dump_wdata=resp at current dump_waddr,
//   then dump_waddr++, timer cleared. After byte ENTRIES-1 (waddr ENTRIES-2) -> FIN status OK; no
//   terminating byte. Timer expiry between bytes -> FIN TIMEOUT, dump_waddr holds count received.
//  resp_rdy and timer expiry in same cycle: byte wins. FIN: done=1, one cycle -> IDLE.
//  Timer width $clog2(TIMEOUT_CYC+1); saturates, no wrap. dump_waddr never exceeds ENTRIES-2.
//  req_vld while busy ignored (not queued); cmd/op held stable until FIN.
// STRUCTURE
//  Shared package cmd_pkg: op constants RD/WR/DMP, ACK=8'hA5, NACK=8'hEE, status_t enum, state_t.
//  (cmd_cfg should import the same op/ACK/NACK constants.)
//  One natural sub-module: resp_timer (clear/enable/expired saturating counter, TIMEOUT_CYC param).
// TESTING (bench pairs this block with cmd_cfg via UART models; TIMEOUT_CYC=200 for sim)
//  WR addr 07 data 3C -> one A5, status OK; follow-up RD addr 07 -> rd_data=3C, OK.
//  RD addr 3F (unmapped) -> rd_data = TrigCfg default 03, status OK.
//  op 11 -> EE received, status NACK; responder forced to send 5A for WR -> BADRESP.
//  DMP ch 3, ENTRIES=8, RAM ch3 = 10..17, ram_addr=2 -> 7 dump_we, addrs 0..6, data 13,14,15,16,17,10,11; OK.
//  DMP with responder stalled after 3 bytes -> done after 200 idle cycles, TIMEOUT, dump_waddr=3.
//  rst asserted during DUMP_RX -> no done, outputs at reset values, next RD completes OK.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the logic-analyzer command protocol.
// Both ends of the link (host initiator and the cmd_cfg responder) import
// this package so opcodes and handshake bytes stay in one place.
//  - OP_* : 2-bit opcode values carried in cmd[15:14]
//  - ACK / NACK : single-byte responses for write and reserved ops
//  - status_t : completion code reported with the done pulse
//  - state_t : host initiator sequencing states
//  - classify() : maps a single response byte to a completion code
package cmd_pkg;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_DMP = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [7:0] ACK  = 8'hA5;
  localparam logic [7:0] NACK = 8'hEE;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_NACK    = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_BADRESP = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_SENT = 3'd2,
    WAIT_RESP = 3'd3,
    DUMP_RX   = 3'd4,
    FIN       = 3'd5
  } state_t;

  // A read accepts any byte as data. A write must be acknowledged with ACK;
  // the reserved opcode is expected to be refused with NACK. Anything else
  // (including a stray single byte for a dump) is a malformed response.
  function automatic status_t classify(input logic [1:0] op, input logic [7:0] r);
    status_t s;
    s = ST_BADRESP;
    case (op)
      OP_RD:  s = ST_OK;
      OP_WR:  s = (r == ACK) ? ST_OK : ((r == NACK) ? ST_NACK : ST_BADRESP);
      OP_RSV: s = (r == NACK) ? ST_NACK : ST_BADRESP;
      default: s = ST_BADRESP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/resp_timer.sv
// Saturating response watchdog.
// Counts enabled clock cycles since the last clear and flags expiry once the
// count reaches TIMEOUT_CYC. The counter parks at the limit instead of
// wrapping, so a stalled link can never alias back to "not expired".
//  clk      in  system clock
//  rst      in  asynchronous, active-high reset
//  clr      in  restart the count from zero (wins over en)
//  en       in  advance the count by one this cycle
//  expired  out count has reached TIMEOUT_CYC
module resp_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYC);

  logic [TW-1:0] count;

  // Clear has priority so a byte arriving on the expiry cycle restarts the
  // window; otherwise the count climbs until it sticks at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + TW'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/host_cmd_init.sv
// Host-side initiator for the logic-analyzer command protocol.
// Accepts one request at a time, hands the 16-bit command word to the UART
// transmitter, then collects the reply from the UART receiver. Single-byte
// replies (RD/WR/reserved) are classified into a status code; a dump streams
// ENTRIES-1 bytes into a capture buffer through the dump_* write port.
// Every request ends with a one-cycle done pulse carrying a held status.
//  clk, rst          clock, asynchronous active-high reset
//  req_vld/op/addr/data, req_rdy   request handshake (ready only in IDLE)
//  cmd, snd_cmd, cmd_sent          command word and UART tx handshake
//  resp, resp_rdy, clr_resp_rdy    UART rx byte and consume handshake
//  dump_we, dump_waddr, dump_wdata capture-buffer write port
//  rd_data           last byte returned by a read
//  done, status      completion pulse and held completion code
module host_cmd_init
  import cmd_pkg::*;
#(
  parameter int unsigned ENTRIES     = 384,
  parameter int unsigned LOG2        = 9,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_vld,
  input  logic [1:0]      req_op,
  input  logic [5:0]      req_addr,
  input  logic [7:0]      req_data,
  output logic            req_rdy,
  output logic [15:0]     cmd,
  output logic            snd_cmd,
  input  logic            cmd_sent,
  input  logic [7:0]      resp,
  input  logic            resp_rdy,
  output logic            clr_resp_rdy,
  output logic            dump_we,
  output logic [LOG2-1:0] dump_waddr,
  output logic [7:0]      dump_wdata,
  output logic [7:0]      rd_data,
  output logic            done,
  output logic [1:0]      status
);

  // Last capture address: a dump returns one byte fewer than the RAM depth.
  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 2);

  state_t  state;
  status_t status_q;

  logic resp_take;
  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  // resp_rdy stays high until the receiver sees clr_resp_rdy, so the cycle in
  // which our clear pulse is out still shows the old byte. Masking with
  // clr_resp_rdy ensures each received byte is consumed exactly once.
  assign resp_take = resp_rdy && !clr_resp_rdy;

  // The response window opens when the command has left the transmitter;
  // before that the timer is held at zero. During a dump every accepted byte
  // reopens the window for the next one.
  assign timer_clr = (state == IDLE) || (state == SEND) || (state == WAIT_SENT) ||
                     ((state == DUMP_RX) && resp_take);
  assign timer_en  = (state == WAIT_RESP) || (state == DUMP_RX);

  resp_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_resp_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  assign status = status_q;

  // Request sequencer. All handshake strobes are registered and default low
  // each cycle so they come out as clean single-cycle pulses. The capture
  // address advances the cycle after each dump write and sticks at the last
  // entry, so after a timeout it reads as the number of bytes received.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_rdy      <= 1'b1;
      cmd          <= '0;
      snd_cmd      <= 1'b0;
      clr_resp_rdy <= 1'b0;
      dump_we      <= 1'b0;
      dump_waddr   <= '0;
      dump_wdata   <= '0;
      rd_data      <= '0;
      done         <= 1'b0;
      status_q     <= ST_OK;
    end else begin
      snd_cmd      <= 1'b0;
      clr_resp_rdy <= 1'b0;
      dump_we      <= 1'b0;
      done         <= 1'b0;

      if (dump_we && (dump_waddr != LAST_ADDR)) begin
        dump_waddr <= dump_waddr + LOG2'(1);
      end

      case (state)
        IDLE: begin
          // A byte with no request outstanding is noise; drain and drop it.
          if (resp_take) begin
            clr_resp_rdy <= 1'b1;
          end
          if (req_vld) begin
            cmd        <= {req_op, req_addr, (req_op == OP_WR) ? req_data : 8'h00};
            dump_waddr <= '0;
            req_rdy    <= 1'b0;
            snd_cmd    <= 1'b1;
            state      <= SEND;
          end
        end

        SEND: begin
          state <= WAIT_SENT;
        end

        WAIT_SENT: begin
          // The transmitter always finishes, so no watchdog here. An early
          // resp_rdy is left untouched until the response state picks it up.
          if (cmd_sent) begin
            state <= (cmd[15:14] == OP_DMP) ? DUMP_RX : WAIT_RESP;
          end
        end

        WAIT_RESP: begin
          // A byte on the expiry cycle still counts as a reply.
          if (resp_take) begin
            clr_resp_rdy <= 1'b1;
            status_q     <= classify(cmd[15:14], resp);
            if (cmd[15:14] == OP_RD) begin
              rd_data <= resp;
            end
            done  <= 1'b1;
            state <= FIN;
          end else if (timer_expired) begin
            status_q <= ST_TIMEOUT;
            done     <= 1'b1;
            state    <= FIN;
          end
        end

        DUMP_RX: begin
          // There is no terminator: the byte landing on the last address
          // completes the dump.
          if (resp_take) begin
            clr_resp_rdy <= 1'b1;
            dump_we      <= 1'b1;
            dump_wdata   <= resp;
            if (dump_waddr == LAST_ADDR) begin
              status_q <= ST_OK;
              done     <= 1'b1;
              state    <= FIN;
            end
          end else if (timer_expired) begin
            status_q <= ST_TIMEOUT;
            done     <= 1'b1;
            state    <= FIN;
          end
        end

        FIN: begin
          req_rdy <= 1'b1;
          state   <= IDLE;
        end

        default: begin
          req_rdy <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_cmd_init.sv
// Self-checking bench for host_cmd_init. A behavioural responder (register
// file plus per-channel dump RAMs) stands in for the remote command block
// and the two UARTs; expected replies, status codes and dump streams come
// from that responder's rules rather than from the design.
module tb_host_cmd_init;

  localparam int ENTRIES     = 8;
  localparam int LOG2        = 3;
  localparam int TIMEOUT_CYC = 200;

  localparam logic [1:0] T_RD  = 2'b00;
  localparam logic [1:0] T_WR  = 2'b01;
  localparam logic [1:0] T_DMP = 2'b10;
  localparam logic [1:0] T_RSV = 2'b11;

  localparam logic [1:0] S_OK      = 2'd0;
  localparam logic [1:0] S_NACK    = 2'd1;
  localparam logic [1:0] S_TIMEOUT = 2'd2;
  localparam logic [1:0] S_BAD     = 2'd3;

  logic            clk;
  logic            rst;
  logic            req_vld;
  logic [1:0]      req_op;
  logic [5:0]      req_addr;
  logic [7:0]      req_data;
  logic            req_rdy;
  logic [15:0]     cmd;
  logic            snd_cmd;
  logic            cmd_sent;
  logic [7:0]      resp;
  logic            resp_rdy;
  logic            clr_resp_rdy;
  logic            dump_we;
  logic [LOG2-1:0] dump_waddr;
  logic [7:0]      dump_wdata;
  logic [7:0]      rd_data;
  logic            done;
  logic [1:0]      status;

  host_cmd_init #(
    .ENTRIES     (ENTRIES),
    .LOG2        (LOG2),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_rdy      (req_rdy),
    .cmd          (cmd),
    .snd_cmd      (snd_cmd),
    .cmd_sent     (cmd_sent),
    .resp         (resp),
    .resp_rdy     (resp_rdy),
    .clr_resp_rdy (clr_resp_rdy),
    .dump_we      (dump_we),
    .dump_waddr   (dump_waddr),
    .dump_wdata   (dump_wdata),
    .rd_data      (rd_data),
    .done         (done),
    .status       (status)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Responder state: register map (unmapped reads return TrigCfg default
  // 03) and one capture RAM per channel 1..5.
  logic [7:0] regs [64];
  logic [7:0] ram  [1:5][ENTRIES];
  int         ram_addr;
  logic [7:0] model_rd;

  logic [7:0]      got_data [$];
  logic [LOG2-1:0] got_addr [$];
  int              done_seen = 0;

  // Capture every dump write and count done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (dump_we) begin
      got_data.push_back(dump_wdata);
      got_addr.push_back(dump_waddr);
    end
    if (done) done_seen++;
  end

  // Runaway guard in case a handshake never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full request: drive it, play the tx/rx UARTs and responder, then
  // check completion. stall_after >= 0 makes the responder go silent after
  // that many bytes; abort returns early (for a reset mid-request).
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] addr,
                               input logic [7:0] data, input int force_byte,
                               input int stall_after, input bit abort);
    logic [7:0]  rsp_q [$];
    logic [15:0] exp_cmd;
    logic [1:0]  exp_status;
    logic [7:0]  reply;
    int          n_send;
    int          cyc;
    int          ch;
    int          exp_waddr;

    got_data.delete();
    got_addr.delete();
    exp_cmd = {op, addr, (op == T_WR) ? data : 8'h00};
    exp_status = S_OK;
    ch = 0;

    case (op)
      T_RD: rsp_q.push_back(regs[addr]);
      T_WR: begin
        regs[addr] = data;
        reply = (force_byte >= 0) ? 8'(force_byte) : 8'hA5;
        rsp_q.push_back(reply);
        exp_status = (reply == 8'hA5) ? S_OK : ((reply == 8'hEE) ? S_NACK : S_BAD);
      end
      T_RSV: begin
        reply = (force_byte >= 0) ? 8'(force_byte) : 8'hEE;
        rsp_q.push_back(reply);
        exp_status = (reply == 8'hEE) ? S_NACK : S_BAD;
      end
      default: begin
        ch = int'(addr[2:0]);
        for (int i = 0; i < ENTRIES - 1; i++) rsp_q.push_back(ram[ch][(ram_addr + 1 + i) % ENTRIES]);
      end
    endcase

    n_send = rsp_q.size();
    if (stall_after >= 0 && stall_after < rsp_q.size()) begin
      n_send = stall_after;
      exp_status = S_TIMEOUT;
    end
    if (op == T_DMP) exp_waddr = (exp_status == S_TIMEOUT) ? n_send : ENTRIES - 2;
    else exp_waddr = 0;

    @(negedge clk);
    checkOutput("req_rdy_idle", req_rdy, 1);
    req_vld = 1'b1; req_op = op; req_addr = addr; req_data = data;
    @(negedge clk);
    req_vld = 1'b0;
    checkOutput("snd_cmd_pulse", snd_cmd, 1);
    checkOutput("cmd_word", cmd, exp_cmd);
    checkOutput("req_rdy_busy", req_rdy, 0);

    // A request while busy must be ignored.
    req_vld = 1'b1; req_op = ~op; req_addr = ~addr; req_data = ~data;
    @(negedge clk);
    req_vld = 1'b0;
    checkOutput("snd_cmd_single", snd_cmd, 0);

    repeat ($urandom_range(0, 5)) @(negedge clk);
    cmd_sent = 1'b1;
    @(negedge clk);
    cmd_sent = 1'b0;

    for (int i = 0; i < n_send; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      resp = rsp_q[i];
      resp_rdy = 1'b1;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!clr_resp_rdy && cyc < 50);
      resp_rdy = 1'b0;
      checkOutput("resp_consumed", clr_resp_rdy, 1);
    end

    if (abort) begin
      repeat (10) @(negedge clk);
      return;
    end

    cyc = 0;
    while (!done && cyc < TIMEOUT_CYC + 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("done_seen", done, 1);
    checkOutput("status", status, exp_status);
    if (exp_status == S_TIMEOUT)
      checkOutput("timeout_window", (cyc >= TIMEOUT_CYC && cyc <= TIMEOUT_CYC + 5), 1);
    if (op == T_RD && exp_status == S_OK) model_rd = rsp_q[0];

    @(negedge clk);
    checkOutput("done_single", done, 0);
    checkOutput("req_rdy_after", req_rdy, 1);
    checkOutput("status_held", status, exp_status);
    checkOutput("cmd_held", cmd, exp_cmd);
    checkOutput("rd_data", rd_data, model_rd);
    checkOutput("dump_waddr", dump_waddr, exp_waddr);
    checkOutput("dump_count", got_data.size(), (op == T_DMP) ? n_send : 0);
    if (op == T_DMP) begin
      for (int i = 0; i < got_data.size() && i < n_send; i++) begin
        checkOutput("dump_data", got_data[i], rsp_q[i]);
        checkOutput("dump_addr", got_addr[i], i);
      end
    end
  endtask

  initial begin
    int seen;
    logic [1:0] rop;
    logic [5:0] raddr;
    int fb;

    rst = 1'b1; req_vld = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
    cmd_sent = 1'b0; resp = '0; resp_rdy = 1'b0;
    model_rd = 8'h00;
    ram_addr = 2;
    for (int i = 0; i < 64; i++) regs[i] = 8'h03;
    for (int c = 1; c <= 5; c++)
      for (int i = 0; i < ENTRIES; i++)
        ram[c][i] = (c == 3) ? 8'(8'h10 + i) : 8'($urandom);

    repeat (3) @(negedge clk);
    $display("[TB] reset values");
    checkOutput("rst_req_rdy", req_rdy, 1);
    checkOutput("rst_cmd", cmd, 0);
    checkOutput("rst_snd_cmd", snd_cmd, 0);
    checkOutput("rst_clr", clr_resp_rdy, 0);
    checkOutput("rst_dump_we", dump_we, 0);
    checkOutput("rst_waddr", dump_waddr, 0);
    checkOutput("rst_wdata", dump_wdata, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_status", status, 0);
    rst = 1'b0;

    $display("[TB] stray byte in idle");
    @(negedge clk);
    resp = 8'h77; resp_rdy = 1'b1;
    @(negedge clk);
    checkOutput("stray_clr", clr_resp_rdy, 1);
    resp_rdy = 1'b0;
    @(negedge clk);
    checkOutput("stray_no_done", done_seen, 0);

    $display("[TB] directed requests");
    applyStimulus(T_WR,  6'h07, 8'h3C, -1, -1, 1'b0);
    applyStimulus(T_RD,  6'h07, 8'h99, -1, -1, 1'b0);
    applyStimulus(T_RD,  6'h3F, 8'h00, -1, -1, 1'b0);
    applyStimulus(T_RSV, 6'h15, 8'h42, -1, -1, 1'b0);
    applyStimulus(T_WR,  6'h12, 8'h55, 8'h5A, -1, 1'b0);
    applyStimulus(T_WR,  6'h13, 8'h66, 8'hEE, -1, 1'b0);
    ram_addr = 2;
    applyStimulus(T_DMP, 6'h03, 8'hFF, -1, -1, 1'b0);
    applyStimulus(T_DMP, 6'h03, 8'h00, -1, 3, 1'b0);
    applyStimulus(T_RD,  6'h07, 8'h00, -1, 0, 1'b0);

    $display("[TB] reset during dump");
    seen = done_seen;
    applyStimulus(T_DMP, 6'h03, 8'h00, -1, 3, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_req_rdy", req_rdy, 1);
    checkOutput("abort_cmd", cmd, 0);
    checkOutput("abort_waddr", dump_waddr, 0);
    checkOutput("abort_rd_data", rd_data, 0);
    checkOutput("abort_status", status, 0);
    checkOutput("abort_dump_we", dump_we, 0);
    rst = 1'b0;
    model_rd = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", done_seen, seen);
    applyStimulus(T_RD, 6'h07, 8'h00, -1, -1, 1'b0);

    $display("[TB] random requests");
    for (int k = 0; k < 12; k++) begin
      rop = 2'($urandom_range(0, 3));
      raddr = 6'($urandom);
      fb = -1;
      if (rop == T_DMP) begin
        raddr = {raddr[5:3], 3'($urandom_range(1, 5))};
        ram_addr = $urandom_range(0, ENTRIES - 1);
      end else if ((rop == T_WR || rop == T_RSV) && ($urandom_range(0, 3) == 0)) begin
        fb = $urandom_range(0, 255);
      end
      applyStimulus(rop, raddr, 8'($urandom), fb, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
